// File: rtl/fpu_uart_pkg.sv
// Shared definitions for the FPU result UART path (TX here, reused by the RX side).
package fpu_uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int UART_BITS      = 8;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = WORD_W / UART_BITS;

  function automatic int bytes_per_word(input int data_w);
    return data_w / UART_BITS;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous result FIFO with a separate occupancy counter and sticky overflow flag.
module fpu_result_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [PTR_W:0]    count,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  logic              full_q, empty_q, overflow_q;
  logic              do_push, do_pop;

  // A pop frees a slot on the same edge, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty_q;
  assign do_push = push && (!full_q || do_pop);

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + (PTR_W+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == (PTR_W+1)'(DEPTH));
      empty_q <= (count_d == '0);
      if (push && !do_push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata    = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign full     = full_q;
  assign empty    = empty_q;
  assign overflow = overflow_q;

endmodule

// File: rtl/fpu_result_uart_tx.sv
// Buffers FPU results and serialises each word as 8N1 bytes, LSB byte first.
module fpu_result_uart_tx
  import fpu_uart_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_W      = 3
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              result_valid,
  input  logic [DATA_W-1:0] result_data,
  input  logic [15:0]       clks_per_bit,
  output logic              tx_serial,
  output logic              tx_busy,
  output logic [PTR_W:0]    fifo_count,
  output logic              fifo_full,
  output logic              overflow
);

  localparam int NBYTES     = bytes_per_word(DATA_W);
  localparam int BYTE_IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [2:0]            LAST_BIT  = 3'(UART_BITS - 1);
  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(NBYTES - 1);

  uart_state_e             state_q;
  logic [15:0]             baud_q, div_q;
  logic [2:0]              bit_idx_q;
  logic [BYTE_IDX_W-1:0]   byte_idx_q;
  logic [DATA_W-1:0]       shift_word_q;
  logic                    tx_q, busy_q;

  logic [DATA_W-1:0]       fifo_rdata;
  logic                    fifo_empty, fifo_pop, bit_done;
  logic [UART_BITS-1:0]    cur_byte;

  assign fifo_pop = (state_q == ST_IDLE) && !fifo_empty;
  assign bit_done = (baud_q == div_q - 16'd1);
  assign cur_byte = shift_word_q[int'(byte_idx_q) * UART_BITS +: UART_BITS];

  fpu_result_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH),
    .PTR_W  (PTR_W)
  ) u_fifo (
    .clk      (clk),
    .rst_l    (rst_l),
    .push     (result_valid),
    .wdata    (result_data),
    .pop      (fifo_pop),
    .rdata    (fifo_rdata),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .overflow (overflow)
  );

  // tx_q always holds the level of the bit being sent, so it is loaded on each transition.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q      <= ST_IDLE;
      baud_q       <= '0;
      div_q        <= 16'd1;
      bit_idx_q    <= '0;
      byte_idx_q   <= '0;
      shift_word_q <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            shift_word_q <= fifo_rdata;
            div_q        <= (clks_per_bit == 16'd0) ? 16'd1 : clks_per_bit;
            byte_idx_q   <= '0;
            bit_idx_q    <= '0;
            baud_q       <= '0;
            tx_q         <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_START;
          end
        end
        ST_START: begin
          if (bit_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            tx_q      <= cur_byte[0];
            state_q   <= ST_DATA;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            baud_q <= '0;
            if (bit_idx_q == LAST_BIT) begin
              tx_q    <= 1'b1;
              state_q <= ST_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= cur_byte[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            baud_q <= '0;
            if (byte_idx_q == LAST_BYTE) begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              byte_idx_q <= byte_idx_q + BYTE_IDX_W'(1);
              tx_q       <= 1'b0;
              state_q    <= ST_START;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign tx_serial = tx_q;
  assign tx_busy   = busy_q;

endmodule

// File: tb/tb_fpu_result_uart_tx.sv
// Directed bench: decodes the TX line cycle-exactly and checks FIFO/overflow behaviour.
module tb_fpu_result_uart_tx;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic        result_valid = 1'b0;
  logic [31:0] result_data = '0;
  logic [15:0] clks_per_bit = 16'd4;
  logic        tx_serial, tx_busy, fifo_full, overflow;
  logic [3:0]  fifo_count;

  int n_checks = 0;
  int n_err    = 0;
  int lat;

  always #5 clk = ~clk;

  fpu_result_uart_tx #(.DATA_W(32), .FIFO_DEPTH(8), .PTR_W(3)) dut (
    .clk          (clk),
    .rst_l        (rst_l),
    .result_valid (result_valid),
    .result_data  (result_data),
    .clks_per_bit (clks_per_bit),
    .tx_serial    (tx_serial),
    .tx_busy      (tx_busy),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    result_valid = 1'b1;
    result_data  = d;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic advance(inout int cyc, input int t);
    repeat (t - cyc) @(negedge clk);
    cyc = t;
  endtask

  // Cycle 0 is the first negedge on which the START bit is seen low.
  task automatic recv_word(input int d, input logic [31:0] exp, input string tag, output int latency);
    int cyc, mid, base;
    logic [31:0] word;
    bit found;
    found = 1'b0;
    latency = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (tx_serial === 1'b0) begin
        found = 1'b1;
        latency = i;
        break;
      end
    end
    check({tag, " start_seen"}, 32'(found), 32'd1);
    if (!found) return;
    check({tag, " busy_at_start"}, 32'(tx_busy), 32'd1);
    cyc  = 0;
    mid  = d / 2;
    word = '0;
    for (int b = 0; b < 4; b++) begin
      base = b * 10 * d;
      advance(cyc, base + mid);
      check({tag, " start_bit"}, 32'(tx_serial), 32'd0);
      for (int k = 0; k < 8; k++) begin
        advance(cyc, base + (k + 1) * d + mid);
        word[8*b+k] = tx_serial;
      end
      advance(cyc, base + 9 * d + mid);
      check({tag, " stop_bit"}, 32'(tx_serial), 32'd1);
      if (b == 3) check({tag, " busy_last_stop"}, 32'(tx_busy), 32'd1);
      advance(cyc, base + 10 * d);
      if (b < 3) begin
        check({tag, " no_gap"}, 32'(tx_serial), 32'd0);
      end else begin
        check({tag, " idle_tx"}, 32'(tx_serial), 32'd1);
        check({tag, " idle_busy"}, 32'(tx_busy), 32'd0);
      end
    end
    check({tag, " word"}, word, exp);
    $display("rx %s: word=%h div=%0d latency=%0d", tag, word, d, latency);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat2;
    // Reset state
    repeat (3) @(negedge clk);
    rst_l = 1'b1;
    repeat (3) @(negedge clk);
    check("rst tx", 32'(tx_serial), 32'd1);
    check("rst busy", 32'(tx_busy), 32'd0);
    check("rst count", 32'(fifo_count), 32'd0);
    check("rst full", 32'(fifo_full), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);

    // Single word, div 4
    clks_per_bit = 16'd4;
    push(32'h3F80_0000);
    check("t1 count_after_push", 32'(fifo_count), 32'd1);
    recv_word(4, 32'h3F80_0000, "t1", lat);
    check("t1 latency", 32'(lat), 32'd1);
    check("t1 count_end", 32'(fifo_count), 32'd0);

    // Zero divisor behaves as 1
    clks_per_bit = 16'd0;
    push(32'hA5A5_A5A5);
    recv_word(1, 32'hA5A5_A5A5, "t4", lat);
    check("t4 latency", 32'(lat), 32'd1);

    // Divisor change mid-word only affects the next word
    clks_per_bit = 16'd4;
    push(32'h1122_3344);
    fork
      recv_word(4, 32'h1122_3344, "t6a", lat);
      begin
        push(32'h5566_7788);
        clks_per_bit = 16'd8;
      end
    join
    recv_word(8, 32'h5566_7788, "t6b", lat);
    check("t6 count_end", 32'(fifo_count), 32'd0);
    check("pre_burst ovf", 32'(overflow), 32'd0);

    // Burst: 9 pushes fill FIFO after the first word is popped
    fork
      recv_word(8, 32'hC0DE_0001, "t2w1", lat);
      begin
        for (int i = 1; i <= 9; i++) begin
          @(negedge clk);
          result_valid = 1'b1;
          result_data  = 32'hC0DE_0000 | 32'(i);
        end
        @(negedge clk);
        result_valid = 1'b0;
        check("t2 count_full", 32'(fifo_count), 32'd8);
        check("t2 full", 32'(fifo_full), 32'd1);
        check("t2 ovf_clear", 32'(overflow), 32'd0);
      end
    join
    // Push lands on the same edge as the pop of word 2
    result_valid = 1'b1;
    result_data  = 32'hC0DE_000A;
    fork
      recv_word(8, 32'hC0DE_0002, "t2w2", lat2);
      begin
        @(negedge clk);
        check("t3 count_stays", 32'(fifo_count), 32'd8);
        check("t3 ovf_clear", 32'(overflow), 32'd0);
        result_data = 32'hC0DE_000B;
        @(negedge clk);
        result_valid = 1'b0;
        check("t2 ovf_set", 32'(overflow), 32'd1);
        check("t2 full_after_drop", 32'(fifo_full), 32'd1);
        check("t2 count_after_drop", 32'(fifo_count), 32'd8);
      end
    join
    check("t2w2 latency", 32'(lat2), 32'd1);
    for (int i = 3; i <= 10; i++) begin
      recv_word(8, 32'hC0DE_0000 | 32'(i), $sformatf("t2w%0d", i), lat);
      check($sformatf("t2w%0d latency", i), 32'(lat), 32'd1);
    end
    check("t2 count_end", 32'(fifo_count), 32'd0);
    check("t2 full_end", 32'(fifo_full), 32'd0);
    check("t2 ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset in the middle of byte 2 data
    clks_per_bit = 16'd4;
    push(32'h1234_5678);
    push(32'hDEAD_BEEF);
    repeat (85) @(negedge clk);
    check("t5 tx_before_rst", 32'(tx_serial), 32'd0);
    check("t5 count_before_rst", 32'(fifo_count), 32'd1);
    #2 rst_l = 1'b0;
    #1;
    check("t5 rst_tx", 32'(tx_serial), 32'd1);
    check("t5 rst_busy", 32'(tx_busy), 32'd0);
    check("t5 rst_count", 32'(fifo_count), 32'd0);
    check("t5 rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_l = 1'b1;
    repeat (5) @(negedge clk);
    check("t5 idle_after_rst", 32'(tx_serial), 32'd1);
    push(32'hCAFE_F00D);
    recv_word(4, 32'hCAFE_F00D, "t5", lat);
    check("t5 latency", 32'(lat), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
